// File: rtl/lsu_mem_master.sv
// Load/store unit driving a word-addressed byte-masked RAM port for RISC-V loads and stores.
// Optional misalignment trap enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu_mem_master #(
  parameter int MEM_AW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_read,
  output logic [3:0]        mem_write,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_RD_WAIT,
    S_RESP,
    S_ERR
  } state_e;

  state_e              state_q, state_d;
  logic                we_q;
  logic [2:0]          funct3_q;
  logic [1:0]          off_q;
  logic [31:0]         wdata_q;
  logic [MEM_AW-1:0]   mem_addr_q;
  logic [31:0]         rdata_q, rdata_d;

  logic                accept;
  logic                funct_ok;
  logic                out_of_range;
  logic                misaligned;
  logic [3:0]          store_mask;
  logic [31:0]         store_data;
  logic [31:0]         load_data;
  logic [7:0]          byte_sel;
  logic [15:0]         half_sel;

  assign req_ready    = rst_n && (state_q == S_IDLE);
  assign accept       = req_valid && req_ready;
  assign out_of_range = |req_addr[31:MEM_AW+2];

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // Unsigned variants exist only for loads.
  always_comb begin
    case (req_funct3)
      3'b000, 3'b001, 3'b010: funct_ok = 1'b1;
      3'b100, 3'b101:         funct_ok = !req_we;
      default:                funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    case (funct3_q[1:0])
      2'b00: begin
        store_mask = 4'b0001 << off_q;
        store_data = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        store_mask = off_q[1] ? 4'b1100 : 4'b0011;
        store_data = {2{wdata_q[15:0]}};
      end
      default: begin
        store_mask = 4'b1111;
        store_data = wdata_q;
      end
    endcase
  end

  assign byte_sel = mem_rdata[{off_q, 3'b000} +: 8];
  assign half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    case (funct3_q[1:0])
      2'b00:   load_data = {{24{byte_sel[7] & ~funct3_q[2]}}, byte_sel};
      2'b01:   load_data = {{16{half_sel[15] & ~funct3_q[2]}}, half_sel};
      default: load_data = mem_rdata;
    endcase
  end

  // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d    = state_q;
    rdata_d    = rdata_q;
    mem_read   = 1'b0;
    mem_write  = 4'b0000;
    mem_wdata  = 32'h0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (out_of_range || !funct_ok || misaligned) begin
            state_d = S_ERR;
            rdata_d = 32'h0;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (we_q) begin
          mem_write = store_mask;
          mem_wdata = store_data;
          rdata_d   = 32'h0;
          state_d   = S_RESP;
        end else begin
          mem_read = 1'b1;
          state_d  = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        rdata_d = load_data;
        state_d = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        state_d    = S_IDLE;
      end
      S_ERR: begin
        resp_valid = 1'b1;
        resp_err   = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      we_q       <= 1'b0;
      funct3_q   <= 3'b000;
      off_q      <= 2'b00;
      wdata_q    <= 32'h0;
      mem_addr_q <= '0;
      rdata_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      if (accept) begin
        we_q     <= req_we;
        funct3_q <= req_funct3;
        off_q    <= req_addr[1:0];
        wdata_q  <= req_wdata;
        if (state_d == S_ISSUE) mem_addr_q <= req_addr[MEM_AW+1:2];
      end
    end
  end

  assign mem_addr   = mem_addr_q;
  assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Self-checking bench for lsu_mem_master: directed vector table, reset corner case and
// randomized traffic against a byte-array reference model.
module tb_lsu_mem_master;
  localparam int MEM_AW = 16;
  localparam logic [31:0] RND_BASE = 32'd400;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_read;
  logic [3:0]        mem_write;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata = 32'h0;

  int n_checks = 0;
  int n_fail   = 0;

  lsu_mem_master #(.MEM_AW(MEM_AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // RAM the unit talks to: read data returned the cycle after mem_read.
  logic [31:0] ram [0:(1<<MEM_AW)-1];
  always @(posedge clk) begin
    if (mem_read) mem_rdata <= ram[mem_addr];
    for (int i = 0; i < 4; i++)
      if (mem_write[i]) ram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
  end

  typedef struct {
    logic              rd;
    logic [3:0]        wmask;
    logic [31:0]       wdata;
    logic [MEM_AW-1:0] maddr;
    int                lat;
    logic              err;
    logic [31:0]       rdata;
  } obs_t;

  typedef struct {
    logic              we;
    logic [2:0]        f3;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic              exp_err;
    logic [31:0]       exp_rdata;
    int                exp_lat;
    logic              exp_rd;
    logic [3:0]        exp_mask;
    logic [31:0]       exp_mdata;
    logic [MEM_AW-1:0] exp_maddr;
  } vec_t;

  vec_t vecs[$];
  logic [7:0] ref_bytes [0:63];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t v(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic err, input logic [31:0] rdata,
                             input int lat, input logic rd, input logic [3:0] mask,
                             input logic [31:0] mdata, input logic [MEM_AW-1:0] maddr);
    vec_t r;
    r = '{we, f3, addr, wdata, err, rdata, lat, rd, mask, mdata, maddr};
    return r;
  endfunction

  // Issue one request starting at posedge+1 and observe the unit until its response.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output obs_t r);
    int n = 0;
    r = '{1'b0, 4'h0, 32'h0, '0, 0, 1'b0, 32'h0};
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    req_valid  = 1'b1;
    while (!req_ready && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("req_ready_before_accept", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (mem_read) r.rd = 1'b1;
      if (mem_write != 4'h0) begin
        r.wmask = mem_write;
        r.wdata = mem_wdata;
      end
      if (mem_read || mem_write != 4'h0) r.maddr = mem_addr;
      if (resp_valid) begin
        r.lat   = c;
        r.err   = resp_err;
        r.rdata = resp_rdata;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  // Reference: memory as bytes, access width from funct3, address rounded down to the width.
  task automatic ref_model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic err,
                           output logic [31:0] rdata, output int lat);
    int size;
    int start;
    int idx;
    logic [31:0] value;
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    err  = 1'b0;
    rdata = 32'h0;
    if (addr >= 32'h0004_0000) err = 1'b1;
    if (f3 == 3'd3 || f3 >= 3'd6 || (we && f3 >= 3'd3)) err = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
    if (addr % size != 0) err = 1'b1;
`endif
    if (err) begin
      lat = 1;
    end else begin
      start = int'(addr) - (int'(addr) % size);
      idx   = start - int'(RND_BASE);
      if (we) begin
        for (int k = 0; k < size; k++) ref_bytes[idx+k] = wdata[8*k +: 8];
        lat = 2;
      end else begin
        value = 32'h0;
        for (int k = 0; k < size; k++) value[8*k +: 8] = ref_bytes[idx+k];
        if (!f3[2] && size < 4 && value[8*size-1])
          for (int k = size; k < 4; k++) value[8*k +: 8] = 8'hFF;
        rdata = value;
        lat = 3;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t r;
    logic exp_err;
    logic [31:0] exp_rdata;
    int exp_lat;
    logic saw_resp;

    for (int i = 0; i < (1 << MEM_AW); i++) ram[i] = 32'h0;
    for (int i = 0; i < 64; i++) ref_bytes[i] = 8'h00;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_funct3 = 3'b000;
    req_addr = 32'h0;
    req_wdata = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_req_ready", {31'b0, req_ready}, 32'd0);
    check("reset_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("reset_mem_outputs", {mem_addr, 11'b0, mem_read, mem_write}, 32'd0);
    check("reset_resp_rdata", resp_rdata, 32'd0);
    rst_n = 1'b1;
    #1;
    check("ready_after_reset", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;

    vecs.push_back(v(1, 3'd2, 32'h0C, 32'h8899AABB, 0, 32'h0, 2, 0, 4'hF, 32'h8899AABB, 3));
    vecs.push_back(v(0, 3'd0, 32'h0D, 32'h0, 0, 32'hFFFFFFAA, 3, 1, 4'h0, 32'h0, 3));
    vecs.push_back(v(0, 3'd4, 32'h0D, 32'h0, 0, 32'h000000AA, 3, 1, 4'h0, 32'h0, 3));
    vecs.push_back(v(0, 3'd1, 32'h0E, 32'h0, 0, 32'hFFFF8899, 3, 1, 4'h0, 32'h0, 3));
    vecs.push_back(v(0, 3'd5, 32'h0E, 32'h0, 0, 32'h00008899, 3, 1, 4'h0, 32'h0, 3));
    vecs.push_back(v(1, 3'd0, 32'h0F, 32'h12345677, 0, 32'h0, 2, 0, 4'h8, 32'h77777777, 3));
    vecs.push_back(v(0, 3'd2, 32'h0C, 32'h0, 0, 32'h7799AABB, 3, 1, 4'h0, 32'h0, 3));
`ifdef LSU_MISALIGN_TRAP_EN
    vecs.push_back(v(0, 3'd2, 32'h0E, 32'h0, 1, 32'h0, 1, 0, 4'h0, 32'h0, 0));
`else
    vecs.push_back(v(0, 3'd2, 32'h0E, 32'h0, 0, 32'h7799AABB, 3, 1, 4'h0, 32'h0, 3));
`endif
    vecs.push_back(v(0, 3'd3, 32'h0C, 32'h0, 1, 32'h0, 1, 0, 4'h0, 32'h0, 0));
    vecs.push_back(v(0, 3'd2, 32'h00040000, 32'h0, 1, 32'h0, 1, 0, 4'h0, 32'h0, 0));
    vecs.push_back(v(1, 3'd4, 32'h0C, 32'h1, 1, 32'h0, 1, 0, 4'h0, 32'h0, 0));
    vecs.push_back(v(1, 3'd1, 32'h12, 32'h0000BEEF, 0, 32'h0, 2, 0, 4'hC, 32'hBEEFBEEF, 4));
    vecs.push_back(v(0, 3'd1, 32'h12, 32'h0, 0, 32'hFFFFBEEF, 3, 1, 4'h0, 32'h0, 4));
    vecs.push_back(v(0, 3'd0, 32'h13, 32'h0, 0, 32'hFFFFFFBE, 3, 1, 4'h0, 32'h0, 4));
    vecs.push_back(v(1, 3'd2, 32'h3FFFC, 32'hCAFEF00D, 0, 32'h0, 2, 0, 4'hF, 32'hCAFEF00D, 16'hFFFF));
    vecs.push_back(v(0, 3'd2, 32'h3FFFC, 32'h0, 0, 32'hCAFEF00D, 3, 1, 4'h0, 32'h0, 16'hFFFF));
    vecs.push_back(v(0, 3'd5, 32'h3FFFE, 32'h0, 0, 32'h0000CAFE, 3, 1, 4'h0, 32'h0, 16'hFFFF));
    vecs.push_back(v(0, 3'd0, 32'h3FFFC, 32'h0, 0, 32'h0000000D, 3, 1, 4'h0, 32'h0, 16'hFFFF));

    foreach (vecs[i]) begin
      do_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, r);
      check($sformatf("v%0d_latency", i), r.lat, vecs[i].exp_lat);
      check($sformatf("v%0d_err", i), {31'b0, r.err}, {31'b0, vecs[i].exp_err});
      check($sformatf("v%0d_rdata", i), r.rdata, vecs[i].exp_rdata);
      check($sformatf("v%0d_mem_read", i), {31'b0, r.rd}, {31'b0, vecs[i].exp_rd});
      check($sformatf("v%0d_mem_write", i), {28'b0, r.wmask}, {28'b0, vecs[i].exp_mask});
      check($sformatf("v%0d_mem_wdata", i), r.wdata, vecs[i].exp_mdata);
      check($sformatf("v%0d_mem_addr", i), {16'b0, r.maddr}, {16'b0, vecs[i].exp_maddr});
      @(posedge clk); #1;
      check($sformatf("v%0d_pulse_and_ready", i), {30'b0, resp_valid, req_ready}, 32'd1);
    end

    // Reset asserted for one edge while a load sits in RD_WAIT.
    req_we = 1'b0;
    req_funct3 = 3'd2;
    req_addr = 32'h0C;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rdwait_reset_ready_low", {31'b0, req_ready}, 32'd0);
    check("rdwait_reset_resp", {30'b0, resp_valid, resp_err}, 32'd0);
    check("rdwait_reset_rdata", resp_rdata, 32'd0);
    check("rdwait_reset_mem", {mem_addr, 11'b0, mem_read, mem_write}, 32'd0);
    check("rdwait_reset_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;
    #1;
    check("rdwait_ready_after_reset", {31'b0, req_ready}, 32'd1);
    saw_resp = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (resp_valid) saw_resp = 1'b1;
    end
    check("rdwait_no_response", {31'b0, saw_resp}, 32'd0);

    for (int t = 0; t < 250; t++) begin
      logic we;
      logic [2:0] f3;
      logic [31:0] addr;
      logic [31:0] wd;
      we   = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      addr = RND_BASE + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 15) == 0) addr = addr | (32'h1 << $urandom_range(18, 31));
      wd   = $urandom;
      ref_model(we, f3, addr, wd, exp_err, exp_rdata, exp_lat);
      do_req(we, f3, addr, wd, r);
      check($sformatf("rnd%0d_err", t), {31'b0, r.err}, {31'b0, exp_err});
      check($sformatf("rnd%0d_rdata", t), r.rdata, exp_rdata);
      check($sformatf("rnd%0d_latency", t), r.lat, exp_lat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
